// File: rtl/ysyx_24080006_addr_chk_if.sv
// Request/response, fault-record and statistics bundle of the address-map checker.
// The DUT sits on the slave side and the LSU/fetch requester sits on the master side.
interface ysyx_24080006_addr_chk_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 16
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic [1:0]        req_type_i;
    logic [ID_W-1:0]   req_id_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [ID_W-1:0]   rsp_id_o;
    logic              rsp_hit_o;
    logic [3:0]        rsp_region_o;
    logic              rsp_ok_o;
    logic              rsp_perip_o;

    logic              fault_valid_o;
    logic [ADDR_W-1:0] fault_addr_o;
    logic [1:0]        fault_type_o;
    logic [1:0]        fault_cause_o;
    logic              fault_ovf_o;
    logic              fault_clr_i;

    logic              cnt_clr_i;
    logic [CNT_W-1:0]  cnt_load_o;
    logic [CNT_W-1:0]  cnt_store_o;
    logic [CNT_W-1:0]  cnt_fetch_o;
    logic [CNT_W-1:0]  cnt_fault_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_type_i, req_id_i, rsp_ready_i,
        input  fault_clr_i, cnt_clr_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_region_o,
        output rsp_ok_o, rsp_perip_o, fault_valid_o, fault_addr_o, fault_type_o,
        output fault_cause_o, fault_ovf_o, cnt_load_o, cnt_store_o, cnt_fetch_o,
        output cnt_fault_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_type_i, req_id_i, rsp_ready_i,
        output fault_clr_i, cnt_clr_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_hit_o, rsp_region_o,
        input  rsp_ok_o, rsp_perip_o, fault_valid_o, fault_addr_o, fault_type_o,
        input  fault_cause_o, fault_ovf_o, cnt_load_o, cnt_store_o, cnt_fetch_o,
        input  cnt_fault_o
    );
endinterface

// File: rtl/ysyx_24080006_addr_chk.sv
// Pipelined address-map checker: region match, permission check, first-fault record
// and saturating per-class access counters behind a single response register slot.
module ysyx_24080006_addr_chk #(
    parameter int                          NUM_REGION   = 8,
    parameter int                          ADDR_W       = 32,
    parameter int                          ID_W         = 4,
    parameter int                          CNT_W        = 16,
    parameter logic [NUM_REGION*ADDR_W-1:0] REGION_BASE = {
        32'h2100_0000, 32'h1001_1000, 32'h1000_2000, 32'h1000_0000,
        32'h0200_0000, 32'ha000_0000, 32'h3000_0000, 32'h0f00_0000},
    parameter logic [NUM_REGION*ADDR_W-1:0] REGION_LIMIT = {
        32'h211f_ffff, 32'h1001_1007, 32'h1000_200f, 32'h1000_0fff,
        32'h0200_ffff, 32'ha3ff_ffff, 32'h30ff_ffff, 32'h0f00_1fff},
    parameter logic [NUM_REGION*3-1:0]      REGION_PERM  = {
        3'b011, 3'b001, 3'b011, 3'b011, 3'b001, 3'b111, 3'b101, 3'b111},
    parameter logic [NUM_REGION-1:0]        REGION_PERIP = 8'b1111_1000
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    ysyx_24080006_addr_chk_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0] TYPE_LOAD  = 2'd0;
    localparam logic [1:0] TYPE_STORE = 2'd1;
    localparam logic [1:0] TYPE_FETCH = 2'd2;
    localparam logic [1:0] TYPE_RSVD  = 2'd3;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'd0;
    localparam logic [1:0] CAUSE_PERM     = 2'd1;
    localparam logic [1:0] CAUSE_RSVD     = 2'd2;

    logic                  accept;
    logic [NUM_REGION-1:0] hit_vec;
    logic                  req_hit;
    logic [3:0]            req_region;
    logic [2:0]            req_perm;
    logic                  req_perip;
    logic                  req_allowed;
    logic                  req_fault;
    logic [1:0]            req_cause;

    logic                  rsp_valid_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic                  rsp_hit_q;
    logic [3:0]            rsp_region_q;
    logic                  rsp_ok_q;
    logic                  rsp_perip_q;

    logic                  fault_valid_q;
    logic [ADDR_W-1:0]     fault_addr_q;
    logic [1:0]            fault_type_q;
    logic [1:0]            fault_cause_q;
    logic                  fault_ovf_q;

    logic [CNT_W-1:0]      cnt_load_q, cnt_store_q, cnt_fetch_q, cnt_fault_q;
    logic [CNT_W-1:0]      base_load, base_store, base_fetch, base_fault;
    logic [CNT_W-1:0]      nxt_load, nxt_store, nxt_fetch, nxt_fault;

    assign bus.req_ready_o = !rsp_valid_q || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_REGION; i++) begin
            hit_vec[i] = (bus.req_addr_i >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                         (bus.req_addr_i <= REGION_LIMIT[i*ADDR_W +: ADDR_W]);
        end
    end

    // Walking downwards lets the lowest-indexed overlapping region win.
    always_comb begin
        req_hit    = 1'b0;
        req_region = 4'd0;
        req_perm   = 3'b000;
        req_perip  = 1'b0;
        for (int i = NUM_REGION - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                req_hit    = 1'b1;
                req_region = 4'(i);
                req_perm   = REGION_PERM[i*3 +: 3];
                req_perip  = REGION_PERIP[i];
            end
        end
    end

    always_comb begin
        req_allowed = 1'b0;
        case (bus.req_type_i)
            TYPE_LOAD:  req_allowed = req_perm[0];
            TYPE_STORE: req_allowed = req_perm[1];
            TYPE_FETCH: req_allowed = req_perm[2];
            default:    req_allowed = 1'b0;
        endcase
        req_fault = (bus.req_type_i == TYPE_RSVD) || !req_hit || !req_allowed;
        if (bus.req_type_i == TYPE_RSVD) begin
            req_cause = CAUSE_RSVD;
        end else if (!req_hit) begin
            req_cause = CAUSE_UNMAPPED;
        end else begin
            req_cause = CAUSE_PERM;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_region_q <= 4'd0;
            rsp_ok_q     <= 1'b0;
            rsp_perip_q  <= 1'b0;
        end else if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= bus.req_id_i;
            rsp_hit_q    <= req_hit;
            rsp_region_q <= req_region;
            rsp_ok_q     <= !req_fault;
            rsp_perip_q  <= req_perip;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    // A clear in the same cycle as a faulting accept makes room for the new record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_type_q  <= 2'd0;
            fault_cause_q <= 2'd0;
            fault_ovf_q   <= 1'b0;
        end else begin
            if (bus.fault_clr_i) begin
                fault_valid_q <= 1'b0;
                fault_ovf_q   <= 1'b0;
            end
            if (accept && req_fault) begin
                if (!fault_valid_q || bus.fault_clr_i) begin
                    fault_valid_q <= 1'b1;
                    fault_addr_q  <= bus.req_addr_i;
                    fault_type_q  <= bus.req_type_i;
                    fault_cause_q <= req_cause;
                end else begin
                    fault_ovf_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        base_load  = bus.cnt_clr_i ? '0 : cnt_load_q;
        base_store = bus.cnt_clr_i ? '0 : cnt_store_q;
        base_fetch = bus.cnt_clr_i ? '0 : cnt_fetch_q;
        base_fault = bus.cnt_clr_i ? '0 : cnt_fault_q;
        nxt_load   = base_load  + CNT_W'(accept && bus.req_type_i == TYPE_LOAD  && base_load  != CNT_MAX);
        nxt_store  = base_store + CNT_W'(accept && bus.req_type_i == TYPE_STORE && base_store != CNT_MAX);
        nxt_fetch  = base_fetch + CNT_W'(accept && bus.req_type_i == TYPE_FETCH && base_fetch != CNT_MAX);
        nxt_fault  = base_fault + CNT_W'(accept && req_fault && base_fault != CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_load_q  <= '0;
            cnt_store_q <= '0;
            cnt_fetch_q <= '0;
            cnt_fault_q <= '0;
        end else begin
            cnt_load_q  <= nxt_load;
            cnt_store_q <= nxt_store;
            cnt_fetch_q <= nxt_fetch;
            cnt_fault_q <= nxt_fault;
        end
    end

    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_id_o      = rsp_id_q;
    assign bus.rsp_hit_o     = rsp_hit_q;
    assign bus.rsp_region_o  = rsp_region_q;
    assign bus.rsp_ok_o      = rsp_ok_q;
    assign bus.rsp_perip_o   = rsp_perip_q;
    assign bus.fault_valid_o = fault_valid_q;
    assign bus.fault_addr_o  = fault_addr_q;
    assign bus.fault_type_o  = fault_type_q;
    assign bus.fault_cause_o = fault_cause_q;
    assign bus.fault_ovf_o   = fault_ovf_q;
    assign bus.cnt_load_o    = cnt_load_q;
    assign bus.cnt_store_o   = cnt_store_q;
    assign bus.cnt_fetch_o   = cnt_fetch_q;
    assign bus.cnt_fault_o   = cnt_fault_q;
endmodule

// File: doc/ysyx_24080006_addr_chk.md
# ysyx_24080006_addr_chk

Parametrised, pipelined address-map checker for the OoO core's LSU and fetch paths. It classifies each request against NUM_REGION inclusive [base, limit] windows and checks per-region load/store/fetch permissions. It also reports whether the hit region is a side-effecting peripheral. It latches the first access fault with an overflow flag and keeps saturating per-class access counters for simulation statistics and difftest.

## Interface
Parameters:
- NUM_REGION, 8: number of address windows; 1..16.
- ADDR_W, 32: address width.
- ID_W, 4: request tag width.
- CNT_W, 16: statistics counter width.
- REGION_BASE, {SRAM 0f00_0000, FLASH 3000_0000, SDRAM a000_0000, CLINT 0200_0000, UART 1000_0000, GPIO 1000_2000, PS2 1001_1000, VGA 2100_0000}: packed NUM_REGION*ADDR_W, region i at slice i.
- REGION_LIMIT, {0f00_1fff, 30ff_ffff, a3ff_ffff, 0200_ffff, 1000_0fff, 1000_200f, 1001_1007, 211f_ffff}: inclusive upper bounds, same packing.
- REGION_PERM, {SRAM LSF, FLASH L-F, SDRAM LSF, CLINT L, UART LS, GPIO LS, PS2 L, VGA LS}: packed NUM_REGION*3, bit0 load, bit1 store, bit2 fetch.
- REGION_PERIP, 8'b1111_1000: 1 = peripheral/uncacheable (CLINT, UART, GPIO, PS2, VGA).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  ADDR_W  access address.
- req_type_i  in  2  00 load, 01 store, 10 fetch, 11 reserved.
- req_id_i  in  ID_W  tag, returned unchanged.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_id_o  out  ID_W  tag of the request.
- rsp_hit_o  out  1  address inside some region.
- rsp_region_o  out  4  index of the hit region; 0 on miss.
- rsp_ok_o  out  1  hit and permitted.
- rsp_perip_o  out  1  hit region is a peripheral; 0 on miss.
- fault_valid_o  out  1  sticky: a fault was captured.
- fault_addr_o  out  ADDR_W  address of the first fault.
- fault_type_o  out  2  req_type of the first fault.
- fault_cause_o  out  2  0 unmapped, 1 permission, 2 reserved type.
- fault_ovf_o  out  1  a further fault occurred while fault_valid_o=1.
- fault_clr_i  in  1  clear the fault record.
- cnt_clr_i  in  1  clear all counters.
- cnt_load_o, cnt_store_o, cnt_fetch_o, cnt_fault_o  out  CNT_W each  accepted-request counts.

## Operation
- Match: region i hits when base_i <= addr <= limit_i (unsigned). On overlap, the lowest index wins.
- Check order: reserved type → cause 2 (rsp_ok_o=0, region/hit still reported); else miss → cause 0; else permission bit clear → cause 1; else ok.
- Output stage is one register slot: req_ready_o = !rsp_valid_o | rsp_ready_i. Accept loads the slot. A consume without an accept empties it.
- Fault capture happens at accept. If fault_valid_o=0, record addr, type and cause and set valid. If valid=1, set ovf only; the record is held.
- fault_clr_i clears valid and ovf. If clear and a faulting accept happen in the same cycle, the new fault is captured and ovf=0.
- Counters increment on accept by type; type 11 counts only in cnt_fault_o. Every faulting accept increments cnt_fault_o. All counters saturate at 2^CNT_W-1.
- cnt_clr_i zeroes the counters; an accept in the same cycle counts 1.

## Timing
- Latency is 1 cycle, accept to rsp_valid_o. Throughput is 1/cycle while rsp_ready_i=1.
- Under backpressure (rsp_valid_o=1, rsp_ready_i=0): all rsp_* outputs stay stable and req_ready_o=0.
- Fault record and counters update at the accept edge. They are visible on the same cycle that rsp_valid_o rises.
- Reset value of every output is 0 except req_ready_o, which is 1 because the slot is empty. Reset mid-transaction drops the pending response.
- req_* inputs are don't-care when req_valid_i=0.

## Test plan
- Default map sweep: load 0f00_0000, 0f00_1fff and 0f00_2000 → region 0 ok; region 0 ok; miss with fault cause 0 and fault_addr_o=0f00_2000.
- Permissions: store to 3000_0010 → region 1, ok=0, cause 1; fetch to 1000_0000 → region 4, perip=1, ok=0; load from 0200_bff8 → region 3, ok=1, perip=1.
- Backpressure: 3 back-to-back loads with rsp_ready_i low for 2 cycles → first response held stable, req_ready_o=0, tags 0,1,2 arrive in order, cnt_load_o=3.
- Fault sticky/ovf: faults at A then B → record holds A and ovf=1. Then fault_clr_i together with fault C → record C, ovf=0.
- Saturation: CNT_W=4, 20 fetches → cnt_fetch_o=15. cnt_clr_i together with an accepted fetch → cnt_fetch_o=1.
- Reserved type 11 at a000_0000 → hit=1, region 2, ok=0, cause 2, cnt_fault_o+1, no type counter change. Assert rst_ni low with a response pending → all outputs 0, req_ready_o=1.
